arb_mux: RTL and testbench



---
 rtl/arb_mux.sv | 124 ++++++++++++
 tb/tb_arb_mux.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux.sv
// arb_mux: N-channel valid/ready stream mux with one registered output stage, direct-select or round-robin.
// Define ARB_MUX_LAST_EN to add in_last/out_last and hold the grant on one channel until a packet ends.
module arb_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
`ifdef ARB_MUX_LAST_EN
  input  logic [NUM_CH-1:0]            in_last,
  output logic                         out_last,
`endif
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_WIDTH-1:0]         out_ch
);

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SEL_WIDTH-1:0]  r_out_ch;
  logic [SEL_WIDTH-1:0]  r_rr_ptr;

  logic                  w_slot_free;
  logic                  w_gnt_vld;
  logic                  w_xfer;
  logic [SEL_WIDTH-1:0]  w_gnt;
  logic [SEL_WIDTH-1:0]  w_gnt_inc;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_locked;
  logic [SEL_WIDTH-1:0]  w_lock_ch;

`ifdef ARB_MUX_LAST_EN
  logic                  r_locked;
  logic [SEL_WIDTH-1:0]  r_lock_ch;
  logic                  r_out_last;

  assign w_locked  = r_locked;
  assign w_lock_ch = r_lock_ch;
  assign out_last  = r_out_last;
`else
  assign w_locked  = 1'b0;
  assign w_lock_ch = '0;
`endif

  assign w_slot_free = ~r_out_valid | out_ready;

  // Round-robin scans from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    if (w_locked) begin
      w_gnt     = w_lock_ch;
      w_gnt_vld = 1'b1;
    end else if (!mode) begin
      w_gnt     = sel;
      w_gnt_vld = (32'(sel) < NUM_CH);
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        idx = int'(r_rr_ptr) + i;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (in_valid[idx]) begin
          w_gnt     = SEL_WIDTH'(idx);
          w_gnt_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NUM_CH; k++)
      in_ready[k] = rst_n & w_gnt_vld & w_slot_free & (w_gnt == SEL_WIDTH'(k));
  end

  assign w_xfer     = rst_n & w_gnt_vld & w_slot_free & in_valid[w_gnt];
  assign w_gnt_inc  = (int'(w_gnt) == NUM_CH - 1) ? '0 : w_gnt + 1'b1;
  assign w_sel_data = in_data[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];

  // Output stage: refilled on accept, emptied on drain, stale data/ch kept when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_ch    <= w_gnt;
      if (mode || w_locked) r_rr_ptr <= w_gnt_inc;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef ARB_MUX_LAST_EN
  // A non-final beat locks onto its channel; the final beat releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked   <= 1'b0;
      r_lock_ch  <= '0;
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_out_last <= in_last[w_gnt];
      r_locked   <= ~in_last[w_gnt];
      r_lock_ch  <= w_gnt;
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: fixed vector table, hand-written reset/lock sequences, randomized run against a model.
module tb_arb_mux;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;
`ifdef ARB_MUX_LAST_EN
  logic [N-1:0]    in_last;
  logic            out_last;
`endif

  int total = 0;
  int bad   = 0;

  arb_mux #(.DATA_WIDTH(DW), .NUM_CH(N), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef ARB_MUX_LAST_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic [SW-1:0] sel;
    logic [N-1:0]  vld;
    logic          ordy;
    logic          last;
    logic [N-1:0]  e_rdy;
    logic          e_vld;
    logic [SW-1:0] e_ch;
    logic [DW-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic md, input int s, input logic [N-1:0] v, input logic ordy,
                              input logic lst, input logic [N-1:0] er, input logic ev, input int ec,
                              input logic [DW-1:0] ed);
    vec_t r;
    r.mode = md; r.sel = SW'(s); r.vld = v; r.ordy = ordy; r.last = lst;
    r.e_rdy = er; r.e_vld = ev; r.e_ch = SW'(ec); r.e_data = ed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic run_row(input vec_t v, input string tag);
    mode = v.mode; sel = v.sel; in_valid = v.vld; out_ready = v.ordy;
`ifdef ARB_MUX_LAST_EN
    in_last = {N{v.last}};
`endif
    #2;
    chk({tag, " in_ready"},  32'(in_ready),  32'(v.e_rdy));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v.e_vld));
    chk({tag, " out_ch"},    32'(out_ch),    32'(v.e_ch));
    chk({tag, " out_data"},  out_data,       v.e_data);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model state: output register contents, round-robin pointer, packet lock.
  logic          m_vld;
  logic [DW-1:0] m_data;
  int            m_ch, m_ptr, m_lch;
  bit            m_lock;
  logic          m_last;

  function automatic int pick(input logic md, input int s, input logic [N-1:0] v);
    if (m_lock) return m_lch;
    if (!md) return (s < N) ? s : -1;
    for (int i = 0; i < N; i++)
      if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  localparam logic [DW-1:0] A0 = 32'hA0, A1 = 32'hA1, A2 = 32'hA2, A3 = 32'hA3;
  vec_t tv[21];
  vec_t lk[5];

  initial begin
    tv[0]  = mk(0, 2, 4'b1111, 1, 1, 4'b0100, 0, 0, 0);
    tv[1]  = mk(0, 2, 4'b1111, 1, 1, 4'b0100, 1, 2, A2);
    tv[2]  = mk(0, 5, 4'b1111, 1, 1, 4'b0000, 1, 2, A2);
    tv[3]  = mk(0, 5, 4'b1111, 1, 1, 4'b0000, 0, 2, A2);
    tv[4]  = mk(1, 0, 4'b1111, 1, 1, 4'b0001, 0, 2, A2);
    tv[5]  = mk(1, 0, 4'b1111, 1, 1, 4'b0010, 1, 0, A0);
    tv[6]  = mk(1, 0, 4'b1111, 1, 1, 4'b0100, 1, 1, A1);
    tv[7]  = mk(1, 0, 4'b1111, 1, 1, 4'b1000, 1, 2, A2);
    tv[8]  = mk(1, 0, 4'b1111, 1, 1, 4'b0001, 1, 3, A3);
    tv[9]  = mk(1, 0, 4'b1010, 1, 1, 4'b0010, 1, 0, A0);
    tv[10] = mk(1, 0, 4'b1010, 1, 1, 4'b1000, 1, 1, A1);
    tv[11] = mk(1, 0, 4'b1010, 1, 1, 4'b0010, 1, 3, A3);
    tv[12] = mk(1, 0, 4'b1010, 1, 1, 4'b1000, 1, 1, A1);
    tv[13] = mk(1, 0, 4'b1111, 0, 1, 4'b0000, 1, 3, A3);
    tv[14] = mk(1, 0, 4'b1111, 0, 1, 4'b0000, 1, 3, A3);
    tv[15] = mk(1, 0, 4'b1111, 0, 1, 4'b0000, 1, 3, A3);
    tv[16] = mk(1, 0, 4'b1111, 1, 1, 4'b0001, 1, 3, A3);
    tv[17] = mk(1, 0, 4'b1111, 1, 1, 4'b0010, 1, 0, A0);
    tv[18] = mk(0, 1, 4'b1111, 1, 1, 4'b0010, 1, 1, A1);
    tv[19] = mk(1, 0, 4'b1111, 1, 1, 4'b0100, 1, 1, A1);
    tv[20] = mk(1, 0, 4'b1111, 1, 1, 4'b1000, 1, 2, A2);

    lk[0]  = mk(0, 2, 4'b0111, 1, 0, 4'b0100, 0, 0, 0);
    lk[1]  = mk(0, 0, 4'b0111, 1, 0, 4'b0100, 1, 2, A2);
    lk[2]  = mk(1, 0, 4'b0111, 1, 1, 4'b0100, 1, 2, A2);
    lk[3]  = mk(1, 0, 4'b0111, 1, 1, 4'b0001, 1, 2, A2);
    lk[4]  = mk(1, 0, 4'b0111, 1, 1, 4'b0010, 1, 0, A0);

    in_data = {A3, A2, A1, A0};
    in_valid = '1; mode = 1'b0; sel = '0; out_ready = 1'b1;
`ifdef ARB_MUX_LAST_EN
    in_last = '1;
`endif
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  32'(in_ready),  0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data",  out_data,       0);
    chk("reset out_ch",    32'(out_ch),    0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) run_row(tv[i], $sformatf("row%0d", i));

    // Asynchronous reset with a word held: discarded, pointer back to 0.
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(out_valid), 0);
    chk("midreset in_ready",  32'(in_ready),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_row(mk(1, 0, 4'b1111, 1, 1, 4'b0001, 0, 0, 0), "after_reset");

`ifdef ARB_MUX_LAST_EN
    do_reset();
    for (int i = 0; i < 5; i++) run_row(lk[i], $sformatf("lock%0d", i));
    do_reset();
    run_row(mk(0, 2, 4'b0111, 1, 0, 4'b0100, 0, 0, 0), "lockrst_a");
    do_reset();
    run_row(mk(1, 0, 4'b1111, 1, 1, 4'b0001, 0, 0, 0), "lockrst_b");
`endif

    // Randomized run against the model.
    do_reset();
    m_vld = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_lock = 1'b0; m_lch = 0; m_last = 1'b0;
    for (int c = 0; c < 400; c++) begin
      int g;
      bit free, xfer;
      logic [N-1:0] er;
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, 7));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) in_data[k*DW +: DW] = $urandom;
`ifdef ARB_MUX_LAST_EN
      in_last = N'($urandom);
`endif
      #2;
      g    = pick(mode, int'(sel), in_valid);
      free = !m_vld || out_ready;
      er   = (g >= 0 && free) ? N'(1 << g) : '0;
      chk("rand in_ready",  32'(in_ready),  32'(er));
      chk("rand out_valid", 32'(out_valid), 32'(m_vld));
      if (m_vld) begin
        chk("rand out_ch",   32'(out_ch), m_ch);
        chk("rand out_data", out_data,    m_data);
`ifdef ARB_MUX_LAST_EN
        chk("rand out_last", 32'(out_last), 32'(m_last));
`endif
      end
      xfer = (g >= 0) && free && in_valid[g];
      if (xfer) begin
        m_vld  = 1'b1;
        m_data = in_data[g*DW +: DW];
        m_ch   = g;
`ifdef ARB_MUX_LAST_EN
        m_last = in_last[g];
        if (m_lock && in_last[g]) begin
          m_lock = 1'b0;
          m_ptr  = (m_lch + 1) % N;
        end else if (!m_lock) begin
          if (mode) m_ptr = (g + 1) % N;
          if (!in_last[g]) begin
            m_lock = 1'b1;
            m_lch  = g;
          end
        end
`else
        if (mode) m_ptr = (g + 1) % N;
`endif
      end else if (out_ready) begin
        m_vld = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
